// File: rtl/ai_player_nxn_if.sv
// Bus between the game controller (master) and the NxN AI opponent (slave).
interface ai_player_nxn_if #(
  parameter int N = 3
) ();
  localparam int NN = N * N;
  localparam int IW = $clog2(NN + 1);

  logic          mode_en;
  logic          new_game;
  logic          game_over;
  logic          move_req;
  logic [NN-1:0] board_human;
  logic [NN-1:0] board_ai;
  logic          move_valid;
  logic [IW-1:0] move_idx;
  logic          no_move;
  logic          busy;
  logic          conflict;

  modport master (
    output mode_en, new_game, game_over, move_req, board_human,
    input  board_ai, move_valid, move_idx, no_move, busy, conflict
  );

  modport slave (
    input  mode_en, new_game, game_over, move_req, board_human,
    output board_ai, move_valid, move_idx, no_move, busy, conflict
  );
endinterface

// File: rtl/ai_player_nxn.sv
// NxN k-in-a-row AI opponent: after each human move it scans for a winning
// cell, then a blocking cell, then falls back to centre / lowest empty cell.
// Cells are 1-based, row-major from top-left; cell i lives in bit N*N-i.
module ai_player_nxn #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  ai_player_nxn_if.slave bus
);
  localparam int NN  = N * N;
  localparam int IW  = $clog2(NN + 1);
  localparam int CTR = (NN + 1) / 2;
  localparam bit ODD = (N % 2) == 1;
  localparam logic [NN-1:0] ONE = {{(NN-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLK, PICK, EMIT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] sel_q, sel_d;
  logic          found_q, found_d;
  logic [NN-1:0] board_ai_q, board_ai_d;
  logic [IW-1:0] move_idx_q, move_idx_d;
  logic          move_valid_q, move_valid_d;
  logic          no_move_q, no_move_d;
  logic          conflict_q, conflict_d;

  // Board-bit mask of the K-1 cells of a window other than position skip.
  function automatic logic [NN-1:0] other_mask(input int sr, input int sc,
                                               input int dr, input int dc,
                                               input int skip);
    logic [NN-1:0] m;
    m = '0;
    for (int j = 0; j < K; j++) begin
      if (j != skip) m = m | (ONE << (NN - 1 - ((sr + j * dr) * N + (sc + j * dc))));
    end
    return m;
  endfunction

  // Per-cell vectors, bit p describes cell p+1.
  logic [NN-1:0] empty_c;
  logic [NN-1:0] hit_win;
  logic [NN-1:0] hit_blk;

  // For every cell, every window through it (4 directions x K offsets) is
  // checked against a constant mask of the other K-1 cells.
  for (genvar p = 0; p < NN; p++) begin : g_cell
    localparam int R = p / N;
    localparam int C = p % N;
    logic [4*K-1:0] w_hit;
    logic [4*K-1:0] b_hit;

    assign empty_c[p] = ~(board_ai_q[NN-1-p] | bus.board_human[NN-1-p]);

    for (genvar d = 0; d < 4; d++) begin : g_dir
      localparam int DR = (d == 0) ? 0 : 1;
      localparam int DC = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      for (genvar j = 0; j < K; j++) begin : g_off
        localparam int SR = R - j * DR;
        localparam int SC = C - j * DC;
        localparam int ER = SR + (K - 1) * DR;
        localparam int EC = SC + (K - 1) * DC;
        if (SR >= 0 && SC >= 0 && SC < N && ER < N && EC >= 0 && EC < N) begin : g_ok
          localparam logic [NN-1:0] M = other_mask(SR, SC, DR, DC, j);
          assign w_hit[d*K+j] = ((board_ai_q & M) == M);
          assign b_hit[d*K+j] = ((bus.board_human & M) == M);
        end else begin : g_no
          assign w_hit[d*K+j] = 1'b0;
          assign b_hit[d*K+j] = 1'b0;
        end
      end
    end

    assign hit_win[p] = (|w_hit) & empty_c[p];
    assign hit_blk[p] = (|b_hit) & empty_c[p];
  end

  // Hit status of the cell currently addressed by the scan counter.
  logic [IW-1:0] cidx;
  logic          win_now;
  logic          blk_now;
  assign cidx    = cnt_q - IW'(1);
  assign win_now = |(hit_win & (ONE << cidx));
  assign blk_now = |(hit_blk & (ONE << cidx));

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [NN-1:0] scan_v;

  // Fallback choice: centre on odd boards if free, else lowest empty cell.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    scan_v   = empty_c;
    if (ODD && empty_c[CTR-1]) begin
      pick_idx = IW'(CTR);
      pick_any = 1'b1;
    end
    for (int i = 1; i <= NN; i++) begin
      if (scan_v[0] && !pick_any) begin
        pick_idx = IW'(i);
        pick_any = 1'b1;
      end
      scan_v = scan_v >> 1;
    end
  end

  // Next-state and output logic; mode_en=0, new_game and game_over override the scan.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    found_d      = found_q;
    board_ai_d   = board_ai_q;
    move_idx_d   = move_idx_q;
    move_valid_d = 1'b0;
    no_move_d    = 1'b0;
    conflict_d   = conflict_q;

    if (state_q != IDLE && (|(bus.board_human & board_ai_q))) conflict_d = 1'b1;

    if (!bus.mode_en) begin
      state_d    = IDLE;
      board_ai_d = '0;
      move_idx_d = '0;
      conflict_d = 1'b0;
    end else if (bus.new_game) begin
      state_d    = IDLE;
      board_ai_d = '0;
      conflict_d = 1'b0;
    end else if (state_q != IDLE && bus.game_over) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.move_req && !bus.game_over) begin
            state_d = SCAN_WIN;
            cnt_d   = IW'(1);
          end
        end
        SCAN_WIN: begin
          if (win_now) begin
            sel_d   = cnt_q;
            found_d = 1'b1;
            state_d = EMIT;
          end else if (cnt_q == IW'(NN)) begin
            cnt_d   = IW'(1);
            state_d = SCAN_BLK;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
        SCAN_BLK: begin
          if (blk_now) begin
            sel_d   = cnt_q;
            found_d = 1'b1;
            state_d = EMIT;
          end else if (cnt_q == IW'(NN)) begin
            state_d = PICK;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
        PICK: begin
          sel_d   = pick_idx;
          found_d = pick_any;
          state_d = EMIT;
        end
        EMIT: begin
          state_d = IDLE;
          if (found_q) begin
            board_ai_d   = board_ai_q | (ONE << (IW'(NN) - sel_q));
            move_idx_d   = sel_q;
            move_valid_d = 1'b1;
          end else begin
            no_move_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      found_q      <= 1'b0;
      board_ai_q   <= '0;
      move_idx_q   <= '0;
      move_valid_q <= 1'b0;
      no_move_q    <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      found_q      <= found_d;
      board_ai_q   <= board_ai_d;
      move_idx_q   <= move_idx_d;
      move_valid_q <= move_valid_d;
      no_move_q    <= no_move_d;
      conflict_q   <= conflict_d;
    end
  end

  assign bus.board_ai   = board_ai_q;
  assign bus.move_valid = move_valid_q;
  assign bus.move_idx   = move_idx_q;
  assign bus.no_move    = no_move_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.conflict   = conflict_q;
endmodule

// File: tb/tb_ai_player_nxn.sv
// Directed bench for ai_player_nxn: a 3x3 instance for most scenarios and a
// 4x4 (K=3) instance for the larger board.
module tb_ai_player_nxn;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ai_player_nxn_if #(.N(3)) if3 ();
  ai_player_nxn_if #(.N(4)) if4 ();

  ai_player_nxn #(.N(3), .K(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));
  ai_player_nxn #(.N(4), .K(3)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a move request; returns just after the accepting edge T.
  task automatic req3(input logic [8:0] hu);
    if3.board_human = hu;
    if3.move_req = 1'b1;
    tick();
    if3.move_req = 1'b0;
  endtask

  task automatic req4(input logic [15:0] hu);
    if4.board_human = hu;
    if4.move_req = 1'b1;
    tick();
    if4.move_req = 1'b0;
  endtask

  task automatic ng3();
    if3.new_game = 1'b1;
    tick();
    if3.new_game = 1'b0;
  endtask

  // Edges until move_valid or no_move appears; -1 if none within the budget.
  task automatic wait3(output int lat, output logic nm);
    lat = -1;
    nm = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (if3.move_valid || if3.no_move) begin
        lat = k;
        nm = if3.no_move;
        break;
      end
    end
  endtask

  task automatic wait4(output int lat);
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (if4.move_valid || if4.no_move) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (if3.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", if3.busy); end
    checks++; if (if3.board_ai !== 9'd0) begin failures++; $display("FAIL rst_board got=%0h exp=0", if3.board_ai); end
    checks++; if (if3.move_idx !== 4'd0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", if3.move_idx); end
    checks++; if ({if3.move_valid, if3.no_move, if3.conflict} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {if3.move_valid, if3.no_move, if3.conflict}); end
    checks++; if (if4.board_ai !== 16'd0) begin failures++; $display("FAIL rst_board4 got=%0h exp=0", if4.board_ai); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_win();
    int lat; logic nm;
    ng3();
    req3(9'b000_010_000);
    wait3(lat, nm);
    checks++; if (lat !== 20 || if3.move_idx !== 4'd1) begin failures++; $display("FAIL win_setup1 got=lat%0d/idx%0d exp=lat20/idx1", lat, if3.move_idx); end
    req3(9'b000_010_010);
    wait3(lat, nm);
    checks++; if (lat !== 12 || if3.move_idx !== 4'd2) begin failures++; $display("FAIL win_setup2 got=lat%0d/idx%0d exp=lat12/idx2", lat, if3.move_idx); end
    req3(9'b000_110_000);
    wait3(lat, nm);
    checks++; if (lat !== 4) begin failures++; $display("FAIL win_lat got=%0d exp=4", lat); end
    checks++; if (if3.move_idx !== 4'd3) begin failures++; $display("FAIL win_idx got=%0d exp=3", if3.move_idx); end
    checks++; if (if3.board_ai !== 9'b111_000_000) begin failures++; $display("FAIL win_board got=%b exp=111000000", if3.board_ai); end
    checks++; if (if3.busy !== 1'b0 || nm !== 1'b0) begin failures++; $display("FAIL win_busy got=%b%b exp=00", if3.busy, nm); end
    tick();
    checks++; if (if3.move_valid !== 1'b0) begin failures++; $display("FAIL win_pulse_width got=%0b exp=0", if3.move_valid); end
  endtask

  task automatic test_block();
    int lat; logic nm;
    ng3();
    req3(9'b100_010_001);
    wait3(lat, nm);
    checks++; if (lat !== 20 || if3.move_idx !== 4'd2) begin failures++; $display("FAIL blk_setup got=lat%0d/idx%0d exp=lat20/idx2", lat, if3.move_idx); end
    req3(9'b100_010_000);
    // A second request while busy must be ignored.
    tick();
    if3.move_req = 1'b1;
    tick();
    if3.move_req = 1'b0;
    wait3(lat, nm);
    checks++; if (lat !== 17) begin failures++; $display("FAIL blk_lat got=%0d exp=17", lat); end
    checks++; if (if3.move_idx !== 4'd9) begin failures++; $display("FAIL blk_idx got=%0d exp=9", if3.move_idx); end
    checks++; if (if3.board_ai !== 9'b010_000_001) begin failures++; $display("FAIL blk_board got=%b exp=010000001", if3.board_ai); end
  endtask

  task automatic test_pick_and_full();
    int lat; logic nm;
    ng3();
    checks++; if (if3.board_ai !== 9'd0) begin failures++; $display("FAIL ng_clear got=%b exp=0", if3.board_ai); end
    req3(9'b100_000_000);
    wait3(lat, nm);
    checks++; if (lat !== 20 || nm !== 1'b0) begin failures++; $display("FAIL pick_lat got=lat%0d/nm%0b exp=lat20/nm0", lat, nm); end
    checks++; if (if3.move_idx !== 4'd5) begin failures++; $display("FAIL pick_idx got=%0d exp=5", if3.move_idx); end
    req3(9'b111_101_111);
    wait3(lat, nm);
    checks++; if (lat !== 20 || nm !== 1'b1 || if3.move_valid !== 1'b0) begin failures++; $display("FAIL full_nomove got=lat%0d/nm%0b/mv%0b exp=lat20/nm1/mv0", lat, nm, if3.move_valid); end
    checks++; if (if3.board_ai !== 9'b000_010_000 || if3.move_idx !== 4'd5) begin failures++; $display("FAIL full_board got=%b/%0d exp=000010000/5", if3.board_ai, if3.move_idx); end
    tick();
    checks++; if (if3.no_move !== 1'b0) begin failures++; $display("FAIL full_pulse_width got=%0b exp=0", if3.no_move); end
  endtask

  task automatic test_game_over();
    int pulses;
    req3(9'b100_000_000);
    for (int k = 0; k < 5; k++) tick();
    checks++; if (if3.busy !== 1'b1) begin failures++; $display("FAIL go_busy_before got=%0b exp=1", if3.busy); end
    if3.game_over = 1'b1;
    tick();
    checks++; if (if3.busy !== 1'b0) begin failures++; $display("FAIL go_abort got=%0b exp=0", if3.busy); end
    if3.game_over = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (if3.move_valid || if3.no_move) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL go_no_pulse got=%0d exp=0", pulses); end
    checks++; if (if3.board_ai !== 9'b000_010_000) begin failures++; $display("FAIL go_board got=%b exp=000010000", if3.board_ai); end
    if3.new_game = 1'b1;
    if3.move_req = 1'b1;
    tick();
    if3.new_game = 1'b0;
    if3.move_req = 1'b0;
    checks++; if (if3.board_ai !== 9'd0 || if3.busy !== 1'b0) begin failures++; $display("FAIL ng_over_req got=%b/%0b exp=0/0", if3.board_ai, if3.busy); end
    tick();
    checks++; if (if3.busy !== 1'b0) begin failures++; $display("FAIL ng_stay_idle got=%0b exp=0", if3.busy); end
  endtask

  task automatic test_conflict_mode();
    int lat; logic nm; int pulses;
    req3(9'b000_010_000);
    wait3(lat, nm);
    checks++; if (if3.move_idx !== 4'd1 || if3.conflict !== 1'b0) begin failures++; $display("FAIL cm_setup got=idx%0d/c%0b exp=idx1/c0", if3.move_idx, if3.conflict); end
    req3(9'b100_000_000);
    tick();
    checks++; if (if3.conflict !== 1'b1) begin failures++; $display("FAIL conflict_set got=%0b exp=1", if3.conflict); end
    wait3(lat, nm);
    checks++; if (if3.conflict !== 1'b1 || if3.move_idx !== 4'd5) begin failures++; $display("FAIL conflict_sticky got=c%0b/idx%0d exp=c1/idx5", if3.conflict, if3.move_idx); end
    req3(9'b000_000_000);
    tick();
    tick();
    if3.mode_en = 1'b0;
    if3.move_req = 1'b1;
    tick();
    if3.move_req = 1'b0;
    checks++; if (if3.busy !== 1'b0 || if3.board_ai !== 9'd0) begin failures++; $display("FAIL mode_off got=busy%0b/board%b exp=0/0", if3.busy, if3.board_ai); end
    checks++; if (if3.move_idx !== 4'd0 || if3.conflict !== 1'b0) begin failures++; $display("FAIL mode_off_idx got=idx%0d/c%0b exp=0/0", if3.move_idx, if3.conflict); end
    tick();
    checks++; if (if3.busy !== 1'b0) begin failures++; $display("FAIL mode_off_ignore got=%0b exp=0", if3.busy); end
    if3.mode_en = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (if3.move_valid || if3.no_move) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL mode_off_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_reset_mid();
    int lat; logic nm; int pulses;
    req3(9'b100_000_000);
    wait3(lat, nm);
    checks++; if (if3.board_ai !== 9'b000_010_000) begin failures++; $display("FAIL rm_setup got=%b exp=000010000", if3.board_ai); end
    req3(9'b100_000_000);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    checks++; if ({if3.busy, if3.move_valid, if3.no_move, if3.conflict} !== 4'b0000 || if3.board_ai !== 9'd0 || if3.move_idx !== 4'd0) begin failures++; $display("FAIL reset_mid got=%b/%b/%0d exp=0000/0/0", {if3.busy, if3.move_valid, if3.no_move, if3.conflict}, if3.board_ai, if3.move_idx); end
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (if3.move_valid || if3.no_move) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_mid_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_n4();
    int lat;
    req4(16'h8000);
    wait4(lat);
    checks++; if (lat !== 34 || if4.move_idx !== 5'd2) begin failures++; $display("FAIL n4_pick got=lat%0d/idx%0d exp=lat34/idx2", lat, if4.move_idx); end
    req4(16'h8400);
    wait4(lat);
    checks++; if (lat !== 28) begin failures++; $display("FAIL n4_blk_lat got=%0d exp=28", lat); end
    checks++; if (if4.move_idx !== 5'd11 || if4.move_valid !== 1'b1) begin failures++; $display("FAIL n4_blk_idx got=%0d/%0b exp=11/1", if4.move_idx, if4.move_valid); end
    checks++; if (if4.board_ai !== 16'h4020) begin failures++; $display("FAIL n4_board got=%0h exp=4020", if4.board_ai); end
  endtask

  initial begin
    if3.mode_en = 1'b1; if3.new_game = 1'b0; if3.game_over = 1'b0;
    if3.move_req = 1'b0; if3.board_human = '0;
    if4.mode_en = 1'b1; if4.new_game = 1'b0; if4.game_over = 1'b0;
    if4.move_req = 1'b0; if4.board_human = '0;
    test_reset();
    test_win();
    test_block();
    test_pick_and_full();
    test_game_over();
    test_conflict_mode();
    test_reset_mid();
    test_n4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
